// File: rtl/sysid_ctrl_pkg.sv
// Shared types and constants for the system-ID boot checker:
// FSM encoding, status register map and status word layout.
package sysid_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD_ID,
      ST_RD_TS,
      ST_CHECK,
      ST_GAP,
      ST_PASS,
      ST_FAIL
   } state_t;

   localparam logic [1:0] REG_STATUS = 2'd0;
   localparam logic [1:0] REG_ID     = 2'd1;
   localparam logic [1:0] REG_TS     = 2'd2;
   localparam logic [1:0] REG_MASK   = 2'd3;

   localparam int BIT_BUSY    = 0;
   localparam int BIT_PASS    = 1;
   localparam int BIT_FAIL    = 2;
   localparam int BIT_ATT_LSB = 4;

   function automatic logic [31:0] status_word(input logic [3:0] attempts,
                                               input logic fail,
                                               input logic pass,
                                               input logic busy);
      logic [31:0] w;
      w = '0;
      w[BIT_ATT_LSB +: 4] = attempts;
      w[BIT_FAIL]         = fail;
      w[BIT_PASS]         = pass;
      w[BIT_BUSY]         = busy;
      return w;
   endfunction

endpackage

// File: rtl/sysid_read_port.sv
// Minimal Avalon-MM read master: one read per go pulse, with a stall
// timeout that abandons the read after TIMEOUT_CYCLES waitrequest cycles.
module sysid_read_port #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        go,
   input  logic        addr,
   input  logic        m_waitrequest,
   input  logic [31:0] m_readdata,
   output logic        m_read,
   output logic        m_address,
   output logic        done,
   output logic        timed_out,
   output logic [31:0] data
);

   // Down-counter of stall cycles still tolerated; zero marks the last one.
   logic [15:0] stall_left;

   assign done      = m_read & ~m_waitrequest;
   assign timed_out = m_read & m_waitrequest & (stall_left == 16'd0);
   assign data      = m_readdata;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         m_read     <= 1'b0;
         m_address  <= 1'b0;
         stall_left <= '0;
      end else if (go) begin
         m_read     <= 1'b1;
         m_address  <= addr;
         stall_left <= 16'(TIMEOUT_CYCLES - 1);
      end else begin
         if (done || timed_out)
            m_read <= 1'b0;
         if (m_read && m_waitrequest && stall_left != 16'd0)
            stall_left <= stall_left - 16'd1;
      end
   end

endmodule

// File: rtl/sysid_boot_checker.sv
// Boot-time system-ID check: reads ID and timestamp, retries on mismatch or
// timeout, gates cpu_release and exposes results on a status slave.
//
// state    | meaning
// ---------+---------------------------------------------------------
// IDLE     | start a new check: attempts=1, launch ID read
// RD_ID    | reading sysid word 0
// RD_TS    | reading sysid word 1
// CHECK    | compare captures, decide PASS / GAP / FAIL
// GAP      | idle RETRY_GAP cycles before the next attempt
// PASS     | sticky success, cpu_release high
// FAIL     | sticky failure, cpu_release high only if boot on fail allowed
module sysid_boot_checker
   import sysid_ctrl_pkg::*;
#(
   parameter logic [31:0] EXPECTED_ID        = 32'd0,
   parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1520801304,
   parameter int          MAX_ATTEMPTS       = 3,
   parameter int          TIMEOUT_CYCLES     = 255,
   parameter int          RETRY_GAP          = 16,
   parameter int          ALLOW_BOOT_ON_FAIL = 0
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   output logic        m_address,
   output logic        m_read,
   input  logic        m_waitrequest,
   input  logic [31:0] m_readdata,
   input  logic [1:0]  s_address,
   input  logic        s_read,
   output logic [31:0] s_readdata,
   output logic        busy,
   output logic        pass,
   output logic        fail,
   output logic        cpu_release
);

   state_t      state;
   logic [3:0]  attempts;
   logic [31:0] cap_id;
   logic [31:0] cap_ts;
   logic        timeout_seen;
   logic [7:0]  gap_left;

   logic        go;
   logic        go_addr;
   logic        rd_done;
   logic        rd_timed_out;
   logic [31:0] rd_data;

   // Launch strobe timed so m_read stays high across the ID->TS handover.
   always_comb begin
      go      = 1'b0;
      go_addr = 1'b0;
      case (state)
         ST_IDLE:  go = 1'b1;
         ST_RD_ID: begin
            go      = rd_done;
            go_addr = 1'b1;
         end
         ST_GAP:   go = (gap_left == 8'd0);
         default:  go = 1'b0;
      endcase
   end

   sysid_read_port #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_read_port (
      .clock         (clock),
      .reset         (reset),
      .go            (go),
      .addr          (go_addr),
      .m_waitrequest (m_waitrequest),
      .m_readdata    (m_readdata),
      .m_read        (m_read),
      .m_address     (m_address),
      .done          (rd_done),
      .timed_out     (rd_timed_out),
      .data          (rd_data)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state        <= ST_IDLE;
         attempts     <= '0;
         cap_id       <= '0;
         cap_ts       <= '0;
         timeout_seen <= 1'b0;
         gap_left     <= '0;
         busy         <= 1'b0;
         pass         <= 1'b0;
         fail         <= 1'b0;
         cpu_release  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               attempts     <= 4'd1;
               timeout_seen <= 1'b0;
               busy         <= 1'b1;
               pass         <= 1'b0;
               fail         <= 1'b0;
               cpu_release  <= 1'b0;
               state        <= ST_RD_ID;
            end
            ST_RD_ID: begin
               if (rd_done) begin
                  cap_id <= rd_data;
                  state  <= ST_RD_TS;
               end else if (rd_timed_out) begin
                  timeout_seen <= 1'b1;
                  state        <= ST_CHECK;
               end
            end
            ST_RD_TS: begin
               if (rd_done) begin
                  cap_ts <= rd_data;
                  state  <= ST_CHECK;
               end else if (rd_timed_out) begin
                  timeout_seen <= 1'b1;
                  state        <= ST_CHECK;
               end
            end
            ST_CHECK: begin
               if (!timeout_seen && cap_id == EXPECTED_ID && cap_ts == EXPECTED_TIMESTAMP) begin
                  busy        <= 1'b0;
                  pass        <= 1'b1;
                  cpu_release <= 1'b1;
                  state       <= ST_PASS;
               end else if (attempts < 4'(MAX_ATTEMPTS)) begin
                  gap_left <= 8'(RETRY_GAP - 1);
                  state    <= ST_GAP;
               end else begin
                  busy        <= 1'b0;
                  fail        <= 1'b1;
                  cpu_release <= (ALLOW_BOOT_ON_FAIL != 0);
                  state       <= ST_FAIL;
               end
            end
            ST_GAP: begin
               if (gap_left == 8'd0) begin
                  if (attempts != 4'hF)
                     attempts <= attempts + 4'd1;
                  timeout_seen <= 1'b0;
                  state        <= ST_RD_ID;
               end else begin
                  gap_left <= gap_left - 8'd1;
               end
            end
            ST_PASS, ST_FAIL: begin
               if (start) begin
                  busy        <= 1'b1;
                  pass        <= 1'b0;
                  fail        <= 1'b0;
                  cpu_release <= 1'b0;
                  state       <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Registered read of pre-edge values, so a same-cycle capture is not visible yet.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         s_readdata <= '0;
      end else if (s_read) begin
         case (s_address)
            REG_STATUS: s_readdata <= status_word(attempts, fail, pass, busy);
            REG_ID:     s_readdata <= cap_id;
            REG_TS:     s_readdata <= cap_ts;
            REG_MASK:   s_readdata <= EXPECTED_ID ^ cap_id;
            default:    s_readdata <= '0;
         endcase
      end
   end

endmodule

// File: tb/tb_sysid_boot_checker.sv
// Scoreboard bench for sysid_boot_checker: a scripted sysid slave, a
// per-run behavioural model, and a monitor checking bus accepts and status reads.
module tb_sysid_boot_checker;

   localparam logic [31:0] EXP_ID = 32'd0;
   localparam logic [31:0] EXP_TS = 32'd1520801304;
   localparam int MAXA  = 3;
   localparam int TOUT  = 4;
   localparam int GAP   = 16;
   localparam int ALLOW = 0;

   logic        clock;
   logic        reset;
   logic        start;
   logic        m_address;
   logic        m_read;
   logic        m_waitrequest;
   logic [31:0] m_readdata;
   logic [1:0]  s_address;
   logic        s_read;
   logic [31:0] s_readdata;
   logic        busy;
   logic        pass;
   logic        fail;
   logic        cpu_release;

   sysid_boot_checker #(
      .EXPECTED_ID        (EXP_ID),
      .EXPECTED_TIMESTAMP (EXP_TS),
      .MAX_ATTEMPTS       (MAXA),
      .TIMEOUT_CYCLES     (TOUT),
      .RETRY_GAP          (GAP),
      .ALLOW_BOOT_ON_FAIL (ALLOW)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .start         (start),
      .m_address     (m_address),
      .m_read        (m_read),
      .m_waitrequest (m_waitrequest),
      .m_readdata    (m_readdata),
      .s_address     (s_address),
      .s_read        (s_read),
      .s_readdata    (s_readdata),
      .busy          (busy),
      .pass          (pass),
      .fail          (fail),
      .cpu_release   (cpu_release)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic [31:0] data;
      int          stall;
   } rd_t;

   typedef struct {
      logic [31:0] id;
      logic [31:0] ts;
      int          sid;
      int          sts;
   } att_t;

   rd_t         slave_q[$];
   logic        addr_q[$];
   logic [31:0] stat_q[$];
   string       stat_name_q[$];

   int vectors;
   int miscompares;

   att_t        plan[15];
   logic [31:0] m_cap_id;
   logic [31:0] m_cap_ts;
   int          m_att;
   bit          m_pass;
   bit          m_fail;
   int          m_cycles;

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic check1(input string name, input logic act, input logic exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   // Scripted sysid slave: each read consumes one planned {data, stall} entry.
   initial begin : slave
      rd_t  cur;
      bit   have;
      int   stalled;
      logic s_mread;
      logic s_wr;
      have          = 1'b0;
      stalled       = 0;
      cur           = '{32'h0, 0};
      m_waitrequest = 1'b0;
      m_readdata    = 32'h0;
      forever begin
         @(negedge clock);
         s_mread = m_read;
         s_wr    = m_waitrequest;
         @(posedge clock);
         #1;
         if (reset) begin
            have = 1'b0;
         end else begin
            if (have && s_mread) begin
               if (!s_wr) have = 1'b0;
               else       stalled++;
            end
            if (have && !m_read) have = 1'b0;
            if (m_read && !have) begin
               if (slave_q.size() == 0) begin
                  vectors++;
                  miscompares++;
                  $display("FAIL unplanned_read: m_read=1 addr=%0d with no planned response", m_address);
                  cur = '{32'hdead_beef, 0};
               end else begin
                  cur = slave_q.pop_front();
               end
               stalled = 0;
               have    = 1'b1;
            end
         end
         m_waitrequest = have && (stalled < cur.stall);
         m_readdata    = have ? cur.data : $urandom();
      end
   end

   // Monitor: checks accepted read addresses and status-read responses.
   initial begin : monitor
      bit          prev_sread;
      logic [31:0] exp;
      string       nm;
      prev_sread = 1'b0;
      forever begin
         @(negedge clock);
         if (prev_sread) begin
            if (stat_q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL status_unexpected: got 0x%08h with nothing expected", s_readdata);
            end else begin
               exp = stat_q.pop_front();
               nm  = stat_name_q.pop_front();
               check32(nm, s_readdata, exp);
            end
         end
         prev_sread = s_read && !reset;
         if (m_read && !m_waitrequest && !reset) begin
            if (addr_q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL accept_unexpected: read accepted at addr %0d with none expected", m_address);
            end else begin
               check1("accept_addr", m_address, addr_q.pop_front());
            end
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic att_t good_att();
      att_t a;
      a = '{EXP_ID, EXP_TS, 0, 0};
      return a;
   endfunction

   // Reference: walk attempts through the check rules, queueing slave replies and accepts.
   task automatic model_run(input bit via_start);
      bit to;
      att_t a;
      m_pass   = 1'b0;
      m_fail   = 1'b0;
      m_cycles = 1 + (via_start ? 1 : 0);
      m_att    = 0;
      for (int k = 1; k <= MAXA; k++) begin
         a     = plan[k-1];
         m_att = k;
         to    = 1'b0;
         if (k > 1) m_cycles += GAP;
         slave_q.push_back('{a.id, a.sid});
         if (a.sid >= TOUT) begin
            m_cycles += TOUT;
            to = 1'b1;
         end else begin
            m_cycles += a.sid + 1;
            m_cap_id = a.id;
            addr_q.push_back(1'b0);
            slave_q.push_back('{a.ts, a.sts});
            if (a.sts >= TOUT) begin
               m_cycles += TOUT;
               to = 1'b1;
            end else begin
               m_cycles += a.sts + 1;
               m_cap_ts = a.ts;
               addr_q.push_back(1'b1);
            end
         end
         m_cycles += 1;
         if (!to && m_cap_id == EXP_ID && m_cap_ts == EXP_TS) begin
            m_pass = 1'b1;
            break;
         end
      end
      m_fail = !m_pass;
   endtask

   task automatic status_reads(input string nm);
      logic [31:0] exp [4];
      exp[0] = {24'b0, 4'(m_att), 1'b0, m_fail, m_pass, 1'b0};
      exp[1] = m_cap_id;
      exp[2] = m_cap_ts;
      exp[3] = EXP_ID ^ m_cap_id;
      for (int a = 0; a < 4; a++) begin
         s_address = 2'(a);
         s_read    = 1'b1;
         stat_q.push_back(exp[a]);
         stat_name_q.push_back($sformatf("%s_status%0d", nm, a));
         @(posedge clock);
         #1;
      end
      s_read = 1'b0;
      repeat (2) begin
         @(posedge clock);
         #1;
      end
      check32({nm, "_status_hold"}, s_readdata, exp[3]);
   endtask

   task automatic do_run(input string nm, input bit via_start, input bit poke);
      int n;
      model_run(via_start);
      n = 0;
      if (via_start) begin
         start = 1'b1;
         @(posedge clock);
         #1;
         start = 1'b0;
         n = 1;
         check1({nm, "_restart_busy"}, busy, 1'b1);
         check1({nm, "_restart_release"}, cpu_release, 1'b0);
      end
      while (!(pass || fail) && n < 3000) begin
         start = (poke && n == 2);
         @(posedge clock);
         #1;
         n++;
      end
      start = 1'b0;
      if (!(pass || fail)) begin
         miscompares++;
         $display("FAIL %s_timeout: neither pass nor fail after %0d cycles", nm, n);
      end
      check32({nm, "_cycles"}, 32'(n), 32'(m_cycles));
      check1({nm, "_pass"}, pass, m_pass);
      check1({nm, "_fail"}, fail, m_fail);
      check1({nm, "_busy"}, busy, 1'b0);
      check1({nm, "_release"}, cpu_release, m_pass || (m_fail && ALLOW != 0));
      check32({nm, "_slave_left"}, 32'(slave_q.size()), 32'd0);
      status_reads(nm);
   endtask

   initial begin : stim
      int wait_n;
      vectors     = 0;
      miscompares = 0;
      m_cap_id    = '0;
      m_cap_ts    = '0;
      reset       = 1'b1;
      start       = 1'b0;
      s_read      = 1'b0;
      s_address   = 2'd0;
      repeat (3) @(posedge clock);
      #1;
      check1("rst_m_read", m_read, 1'b0);
      check1("rst_m_address", m_address, 1'b0);
      check1("rst_busy", busy, 1'b0);
      check1("rst_pass", pass, 1'b0);
      check1("rst_fail", fail, 1'b0);
      check1("rst_release", cpu_release, 1'b0);
      check32("rst_s_readdata", s_readdata, 32'h0);
      reset = 1'b0;

      for (int k = 0; k < 15; k++) plan[k] = good_att();
      do_run("t1_clean", 1'b0, 1'b0);

      for (int k = 0; k < 15; k++) begin
         plan[k]    = good_att();
         plan[k].ts = EXP_TS + 32'd1;
      end
      do_run("t2_ts_mismatch", 1'b1, 1'b0);

      for (int k = 0; k < 15; k++) begin
         plan[k]     = good_att();
         plan[k].sid = 1000;
      end
      do_run("t3_stall_timeout", 1'b1, 1'b0);

      for (int k = 0; k < 15; k++) plan[k] = good_att();
      plan[0].sid = 3;
      do_run("t4_stall_accept", 1'b1, 1'b0);

      for (int k = 0; k < 15; k++) plan[k] = good_att();
      plan[0].id = 32'h0000_0100;
      do_run("t5_retry_pass", 1'b1, 1'b0);

      // Reset while the timestamp read is stalled.
      start = 1'b1;
      @(posedge clock);
      #1;
      start = 1'b0;
      slave_q.push_back('{EXP_ID, 0});
      slave_q.push_back('{EXP_TS, 50});
      addr_q.push_back(1'b0);
      wait_n = 0;
      while (!(m_read && m_address && m_waitrequest) && wait_n < 50) begin
         @(posedge clock);
         #1;
         wait_n++;
      end
      check1("t6_reached_rd_ts", m_read && m_address && m_waitrequest, 1'b1);
      #2;
      reset = 1'b1;
      #1;
      check1("t6_async_m_read", m_read, 1'b0);
      check1("t6_async_busy", busy, 1'b0);
      check1("t6_async_pass", pass, 1'b0);
      check1("t6_async_fail", fail, 1'b0);
      check1("t6_async_release", cpu_release, 1'b0);
      check32("t6_async_s_readdata", s_readdata, 32'h0);
      slave_q.delete();
      addr_q.delete();
      m_cap_id = '0;
      m_cap_ts = '0;
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
      for (int k = 0; k < 15; k++) plan[k] = good_att();
      do_run("t6_rerun", 1'b0, 1'b0);

      for (int r = 0; r < 25; r++) begin
         for (int k = 0; k < 15; k++) begin
            plan[k]     = good_att();
            plan[k].sid = $urandom_range(0, TOUT - 1);
            plan[k].sts = $urandom_range(0, TOUT - 1);
            case ($urandom_range(0, 9))
               5: plan[k].id  = EXP_ID ^ (32'd1 << $urandom_range(0, 31));
               6: plan[k].ts  = EXP_TS ^ (32'd1 << $urandom_range(0, 31));
               7: plan[k].sid = TOUT + $urandom_range(0, 10);
               8: plan[k].sts = TOUT + $urandom_range(0, 10);
               9: begin
                  plan[k].id = $urandom();
                  plan[k].ts = $urandom();
               end
               default: ;
            endcase
         end
         do_run($sformatf("rnd%0d", r), 1'b1, 1'($urandom_range(0, 1)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
